hnf_txreq_link: RTL and testbench

//  HN-F -> SN-F CHI TXREQ link-layer transmitter. Up to NUM_SRC internal request sources are merged
//  by a round-robin arbiter into a DEPTH-entry flit FIFO. Flits drain only against L-credits held
//  in a counter. The block runs the TXLINKACTIVE handshake, including return of credits on deactivate.

---
 rtl/hnf_pkg.sv | 26 ++
 rtl/hnf_rr_arb.sv | 47 ++++
 rtl/hnf_txreq_link.sv | 129 ++++++++++++
 tb/tb_hnf_txreq_link.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hnf_pkg.sv
// Shared CHI request-channel types for the HN-F transmit path.
// Flit layout, link-state encoding and credit limits.
package hnf_pkg;

    localparam int CHI_MAX_LCRD = 15;

    localparam logic [5:0] REQ_OPC_LCRDRETURN = 6'h00;
    localparam logic [5:0] REQ_OPC_READNOSNP  = 6'h04;

    typedef enum logic [1:0] {
        STOP       = 2'd0,
        ACTIVATE   = 2'd1,
        RUN        = 2'd2,
        DEACTIVATE = 2'd3
    } txlink_state_e;

    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [5:0]  opcode;
        logic [47:0] addr;
    } reqflit_t;

endpackage

// File: rtl/hnf_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the
// pointer; the pointer moves past the winner when the grant is taken.
module hnf_rr_arb #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] NL = (PW+1)'(N);

    logic [PW-1:0] ptr_q, ptr_d, gidx;
    logic [PW:0]   sum;
    logic          hit;

    always_comb begin
        grant_o = '0;
        gidx    = '0;
        hit     = 1'b0;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= NL) sum = sum - NL;
            if (!hit && req_i[sum[PW-1:0]]) begin
                hit  = 1'b1;
                gidx = sum[PW-1:0];
            end
        end
        if (hit) grant_o[gidx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && hit)
            ptr_d = (gidx == PW'(N-1)) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/hnf_txreq_link.sv
// HN-F to SN-F CHI TXREQ link transmitter.
// Arbitration, flit FIFO, L-credits, link handshake.
module hnf_txreq_link
  import hnf_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 4,
  parameter int MAX_LCRD = CHI_MAX_LCRD
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          link_en,
  input  reqflit_t [NUM_SRC-1:0]        src_flit,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          TXLINKACTIVEREQ,
  input  logic                          TXLINKACTIVEACK,
  output logic                          TXREQFLITPEND,
  output logic                          TXREQFLITV,
  output reqflit_t                      TXREQFLIT,
  input  logic                          TXREQLCRDV,
  output txlink_state_e                 link_state,
  output logic [$clog2(MAX_LCRD+1)-1:0] crd_count,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
  output logic                          err_crd_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_LCRD+1);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LCRD);

  txlink_state_e      state_q;
  reqflit_t           mem_q [DEPTH];
  logic [AW:0]        wr_q, rd_q, used;
  logic [CW-1:0]      crd_q, crd_d;
  logic               flitv_q, err_q;
  reqflit_t           flit_q, push_flit;
  logic [NUM_SRC-1:0] grant;
  logic               empty, full, open;
  logic               push, send_data, send_ret, send;
  logic               crd_ovf, crd_inc;

  assign used  = wr_q - rd_q;
  assign empty = (used == '0);
  assign full  = (used == (AW+1)'(DEPTH));
  assign open  = (state_q == RUN) && !full;

  hnf_rr_arb #(.N(NUM_SRC)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_i   (src_valid),
    .adv_i   (push),
    .grant_o (grant)
  );

  assign src_ready = open ? grant : '0;
  assign push      = |src_ready;

  always_comb begin
    push_flit = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_ready[i]) push_flit = src_flit[i];
  end

  assign send_data = (state_q == RUN) && !empty
                     && (crd_q != '0);
  assign send_ret  = (state_q == DEACTIVATE)
                     && (crd_q != '0);
  assign send      = send_data | send_ret;

  assign crd_ovf = TXREQLCRDV &&
                   ((state_q == STOP) || (crd_q == CMAX));
  assign crd_inc = TXREQLCRDV && !crd_ovf;

  always_comb begin
    crd_d = crd_q;
    if (crd_inc && !send)      crd_d = crd_q + CW'(1);
    else if (!crd_inc && send) crd_d = crd_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_flit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= STOP;
      wr_q    <= '0;
      rd_q    <= '0;
      crd_q   <= '0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_q + (AW+1)'(push);
      rd_q    <= rd_q + (AW+1)'(send_data);
      crd_q   <= crd_d;
      flitv_q <= send;
      flit_q  <= send_data ? mem_q[rd_q[AW-1:0]] : '0;
      if (crd_ovf) err_q <= 1'b1;
      unique case (state_q)
        STOP:
          if (link_en) state_q <= ACTIVATE;
        ACTIVATE:
          if (TXLINKACTIVEACK) state_q <= RUN;
        RUN:
          if (!link_en && empty && !push)
            state_q <= DEACTIVATE;
        DEACTIVATE:
          if (!TXLINKACTIVEACK && crd_q == '0 &&
              !TXREQLCRDV)
            state_q <= STOP;
        default: state_q <= STOP;
      endcase
    end
  end

  assign TXLINKACTIVEREQ = (state_q == ACTIVATE) ||
                           (state_q == RUN);
  assign TXREQFLITPEND   = (state_q != STOP);
  assign TXREQFLITV      = flitv_q;
  assign TXREQFLIT       = flit_q;
  assign link_state      = state_q;
  assign crd_count       = crd_q;
  assign fifo_count      = FW'(used);
  assign err_crd_ovf     = err_q;

endmodule

// File: tb/tb_hnf_txreq_link.sv
// Self-checking bench for hnf_txreq_link: directed link scenarios
// followed by randomized traffic against a queue-based reference model.
module tb_hnf_txreq_link;
    import hnf_pkg::*;

    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 4;
    localparam int MAX_LCRD = 15;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   link_en = 1'b0;
    logic                   ack = 1'b0;
    logic                   lcrdv = 1'b0;
    reqflit_t [NUM_SRC-1:0] src_flit = '0;
    logic [NUM_SRC-1:0]     src_valid = '0;
    logic [NUM_SRC-1:0]     src_ready;
    logic                   req, pend, flitv, err;
    reqflit_t               flit;
    txlink_state_e          link_state;
    logic [3:0]             crd_count;
    logic [2:0]             fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hnf_txreq_link #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .MAX_LCRD(MAX_LCRD)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .link_en         (link_en),
        .src_flit        (src_flit),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .TXLINKACTIVEREQ (req),
        .TXLINKACTIVEACK (ack),
        .TXREQFLITPEND   (pend),
        .TXREQFLITV      (flitv),
        .TXREQFLIT       (flit),
        .TXREQLCRDV      (lcrdv),
        .link_state      (link_state),
        .crd_count       (crd_count),
        .fifo_count      (fifo_count),
        .err_crd_ovf     (err)
    );

    // Reference model: state 0=STOP 1=ACTIVATE 2=RUN 3=DEACTIVATE
    int       m_st = 0;
    int       m_crd = 0;
    int       m_rr = 0;
    reqflit_t m_q[$];
    bit       m_flitv = 0;
    bit       m_err = 0;
    reqflit_t m_flit = '0;

    function automatic int mdl_grant();
        if (m_st != 2 || m_q.size() >= DEPTH) return -1;
        for (int i = 0; i < NUM_SRC; i++) begin
            int k;
            k = (m_rr + i) % NUM_SRC;
            if (src_valid[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin : mdl
        int g, c0;
        bit sd, sr, ovf, q0;
        if (!reset) begin
            m_st = 0; m_crd = 0; m_rr = 0; m_q.delete();
            m_flitv = 0; m_err = 0; m_flit = '0;
        end else begin
            g  = mdl_grant();
            c0 = m_crd;
            q0 = (m_q.size() == 0);
            sd = (m_st == 2) && !q0 && c0 > 0;
            sr = (m_st == 3) && c0 > 0;
            ovf = lcrdv && (m_st == 0 || c0 == MAX_LCRD);
            m_flitv = sd || sr;
            m_flit  = sd ? m_q[0] : '0;
            if (sd) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(src_flit[g]);
                m_rr = (g + 1) % NUM_SRC;
            end
            if (lcrdv && !ovf) m_crd++;
            if (sd || sr) m_crd--;
            if (ovf) m_err = 1;
            case (m_st)
                0: if (link_en) m_st = 1;
                1: if (ack) m_st = 2;
                2: if (!link_en && q0 && g < 0) m_st = 3;
                3: if (!ack && c0 == 0 && !lcrdv) m_st = 0;
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic reqflit_t rnd_flit();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    task automatic test_reset();
        src_valid = 2'b11;
        #12;
        checks++; if (link_state !== STOP) begin errors++; $display("FAIL reset_state: got %0d want 0", link_state); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", pend); end
        checks++; if (flitv !== 1'b0 || flit !== '0) begin errors++; $display("FAIL reset_flit: got v=%b %h want 0", flitv, flit); end
        checks++; if (crd_count !== 4'd0 || fifo_count !== 3'd0) begin errors++; $display("FAIL reset_counts: got crd=%0d fifo=%0d want 0", crd_count, fifo_count); end
        checks++; if (src_ready !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL reset_ready_err: got rdy=%b err=%b want 0", src_ready, err); end
        src_valid = '0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_activate();
        link_en = 1'b1;
        step();
        checks++; if (link_state !== ACTIVATE || req !== 1'b1) begin errors++; $display("FAIL act_req: got st=%0d req=%b want 1/1", link_state, req); end
        ack = 1'b1;
        step();
        checks++; if (link_state !== RUN || req !== 1'b1 || pend !== 1'b1) begin errors++; $display("FAIL act_run: got st=%0d req=%b pend=%b want 2/1/1", link_state, req, pend); end
        checks++; if (crd_count !== 4'd0 || flitv !== 1'b0) begin errors++; $display("FAIL act_idle: got crd=%0d v=%b want 0/0", crd_count, flitv); end
    endtask

    task automatic test_no_credit();
        reqflit_t e[3];
        for (int i = 0; i < 3; i++) begin
            e[i] = rnd_flit();
            src_flit[0] = e[i];
            src_valid = 2'b01;
            #1;
            checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL nocrd_ready%0d: got %b want 01", i, src_ready); end
            step();
        end
        src_valid = '0;
        checks++; if (fifo_count !== 3'd3 || flitv !== 1'b0) begin errors++; $display("FAIL nocrd_hold: got fifo=%0d v=%b want 3/0", fifo_count, flitv); end
        for (int i = 0; i < 2; i++) begin
            lcrdv = 1'b1;
            step();
            checks++; if (flitv !== 1'b0 || crd_count !== 4'd1) begin errors++; $display("FAIL nocrd_grant%0d: got v=%b crd=%0d want 0/1", i, flitv, crd_count); end
            lcrdv = 1'b0;
            step();
            checks++; if (flitv !== 1'b1 || flit !== e[i]) begin errors++; $display("FAIL nocrd_out%0d: got v=%b %h want 1 %h", i, flitv, flit, e[i]); end
        end
        step();
        checks++; if (flitv !== 1'b0 || fifo_count !== 3'd1 || crd_count !== 4'd0) begin errors++; $display("FAIL nocrd_end: got v=%b fifo=%0d crd=%0d want 0/1/0", flitv, fifo_count, crd_count); end
    endtask

    task automatic test_fairness();
        logic [1:0] want;
        src_valid = 2'b11;
        lcrdv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            src_flit[0] = rnd_flit();
            src_flit[1] = rnd_flit();
            #1;
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if (src_ready !== want) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", i, src_ready, want); end
            step();
        end
        lcrdv = 1'b0;
        repeat (4) step();
        #1;
        checks++; if (src_ready !== 2'b00 || fifo_count !== 3'd4) begin errors++; $display("FAIL fair_full: got rdy=%b fifo=%0d want 00/4", src_ready, fifo_count); end
        src_valid = '0;
    endtask

    task automatic test_concurrency();
        int n;
        lcrdv = 1'b1;
        step();
        checks++; if (crd_count !== 4'd1) begin errors++; $display("FAIL conc_one: got %0d want 1", crd_count); end
        step();
        checks++; if (crd_count !== 4'd1 || flitv !== 1'b1 || fifo_count !== 3'd3) begin errors++; $display("FAIL conc_same: got crd=%0d v=%b fifo=%0d want 1/1/3", crd_count, flitv, fifo_count); end
        n = 0;
        while (crd_count < 4'd15 && n < 40) begin
            step();
            n++;
        end
        checks++; if (crd_count !== 4'd15 || err !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL conc_max: got crd=%0d err=%b fifo=%0d want 15/0/0", crd_count, err, fifo_count); end
        step();
        checks++; if (crd_count !== 4'd15 || err !== 1'b1) begin errors++; $display("FAIL conc_ovf: got crd=%0d err=%b want 15/1", crd_count, err); end
        lcrdv = 1'b0;
    endtask

    task automatic test_reset_midop();
        src_flit[0] = rnd_flit();
        src_valid = 2'b01;
        step();
        step();
        checks++; if (flitv !== 1'b1 || fifo_count !== 3'd1 || crd_count !== 4'd14) begin errors++; $display("FAIL rst_pre: got v=%b fifo=%0d crd=%0d want 1/1/14", flitv, fifo_count, crd_count); end
        #1 reset = 1'b0;
        #1;
        checks++; if (flitv !== 1'b0 || flit !== '0 || crd_count !== 4'd0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rst_async_data: got v=%b crd=%0d fifo=%0d want 0", flitv, crd_count, fifo_count); end
        checks++; if (req !== 1'b0 || pend !== 1'b0 || err !== 1'b0 || src_ready !== 2'b00) begin errors++; $display("FAIL rst_async_ctl: got req=%b pend=%b err=%b rdy=%b want 0", req, pend, err, src_ready); end
        src_valid = '0;
        link_en = 1'b0;
        ack = 1'b0;
        #3 reset = 1'b1;
        step();
        checks++; if (link_state !== STOP) begin errors++; $display("FAIL rst_release: got %0d want 0", link_state); end
    endtask

    task automatic test_deactivate();
        link_en = 1'b1;
        step();
        lcrdv = 1'b1;
        repeat (3) step();
        lcrdv = 1'b0;
        checks++; if (link_state !== ACTIVATE || crd_count !== 4'd3) begin errors++; $display("FAIL deact_pre: got st=%0d crd=%0d want 1/3", link_state, crd_count); end
        ack = 1'b1;
        step();
        link_en = 1'b0;
        step();
        checks++; if (link_state !== DEACTIVATE || req !== 1'b0 || pend !== 1'b1) begin errors++; $display("FAIL deact_req: got st=%0d req=%b pend=%b want 3/0/1", link_state, req, pend); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flitv !== 1'b1 || flit.opcode !== REQ_OPC_LCRDRETURN || flit !== '0 || crd_count !== 4'(2 - i)) begin errors++; $display("FAIL deact_ret%0d: got v=%b opc=%h crd=%0d want 1/00/%0d", i, flitv, flit.opcode, crd_count, 2 - i); end
        end
        step();
        checks++; if (flitv !== 1'b0) begin errors++; $display("FAIL deact_idle: got v=%b want 0", flitv); end
        lcrdv = 1'b1;
        step();
        lcrdv = 1'b0;
        step();
        checks++; if (flitv !== 1'b1 || crd_count !== 4'd0) begin errors++; $display("FAIL deact_late: got v=%b crd=%0d want 1/0", flitv, crd_count); end
        ack = 1'b0;
        step();
        checks++; if (link_state !== STOP || pend !== 1'b0 || crd_count !== 4'd0) begin errors++; $display("FAIL deact_stop: got st=%0d pend=%b crd=%0d want 0/0/0", link_state, pend, crd_count); end
    endtask

    task automatic test_random();
        logic [1:0] want_rdy;
        int g;
        link_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 29) == 0) link_en = ~link_en;
            case (m_st)
                1:       ack = ($urandom_range(0, 1) == 1);
                2:       ack = 1'b1;
                3:       if ($urandom_range(0, 2) == 0) ack = 1'b0;
                default: ack = 1'b0;
            endcase
            lcrdv = (m_st != 0) && (m_crd < MAX_LCRD) && ($urandom_range(0, 2) == 0);
            src_valid = 2'($urandom());
            src_flit[0] = rnd_flit();
            src_flit[1] = rnd_flit();
            #1;
            g = mdl_grant();
            want_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            checks++; if (src_ready !== want_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, src_ready, want_rdy); end
            step();
            checks++; if (link_state !== txlink_state_e'(m_st) || req !== (m_st == 1 || m_st == 2) || pend !== (m_st != 0)) begin errors++; $display("FAIL rnd_link c%0d: got st=%0d req=%b pend=%b want st=%0d", c, link_state, req, pend, m_st); end
            checks++; if (flitv !== m_flitv || flit !== m_flit) begin errors++; $display("FAIL rnd_flit c%0d: got v=%b %h want v=%b %h", c, flitv, flit, m_flitv, m_flit); end
            checks++; if (crd_count !== 4'(m_crd) || fifo_count !== 3'(m_q.size()) || err !== m_err) begin errors++; $display("FAIL rnd_cnt c%0d: got crd=%0d fifo=%0d err=%b want %0d/%0d/%b", c, crd_count, fifo_count, err, m_crd, m_q.size(), m_err); end
        end
        src_valid = '0;
        lcrdv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_activate();
        test_no_credit();
        test_fairness();
        test_concurrency();
        test_reset_midop();
        test_deactivate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
